// File: rtl/csr_pkg.sv
// csr_pkg: CSR numbers, register field positions, exception codes and write helpers
// shared by csr_unit and csr_timer.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0c;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    // CRMD fields
    localparam int CRMD_PLV_LO  = 0;
    localparam int CRMD_PLV_HI  = 1;
    localparam int CRMD_IE      = 2;
    localparam int CRMD_DA      = 3;
    localparam int CRMD_PG      = 4;
    localparam int CRMD_DATF_LO = 5;
    localparam int CRMD_DATF_HI = 6;
    localparam int CRMD_DATM_LO = 7;
    localparam int CRMD_DATM_HI = 8;
    localparam logic [8:0] CRMD_RST = 9'h008;

    // PRMD fields
    localparam int PRMD_PPLV_LO = 0;
    localparam int PRMD_PPLV_HI = 1;
    localparam int PRMD_PIE     = 2;

    // ECFG / ESTAT fields
    localparam int ECFG_LIE_LO     = 0;
    localparam int ECFG_LIE_HI     = 12;
    localparam int ESTAT_IS_LO     = 0;
    localparam int ESTAT_IS_HI     = 12;
    localparam int ESTAT_IS_SW_HI  = 1;
    localparam int ESTAT_IS_HW_LO  = 2;
    localparam int ESTAT_IS_HW_HI  = 9;
    localparam int ESTAT_IS_TI     = 11;
    localparam int ESTAT_IS_IPI    = 12;
    localparam int ESTAT_ECODE_LO  = 16;
    localparam int ESTAT_ECODE_HI  = 21;
    localparam int ESTAT_ESUB_LO   = 22;
    localparam int ESTAT_ESUB_HI   = 30;
    localparam logic [12:0] LIE_WMASK = 13'h1bff;

    // EENTRY / timer fields
    localparam int EENTRY_VA_LO    = 6;
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;
    localparam int TICLR_CLR       = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    function automatic logic [31:0] csr_mwrite(input logic [31:0] old_v,
                                               input logic [31:0] mask,
                                               input logic [31:0] val);
        return (mask & val) | (~mask & old_v);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// csr_timer: TCFG/TVAL countdown timer and the timer interrupt flag ESTAT.IS[11].
// Only instantiated when CSR_TIMER_EN is defined.
module csr_timer
    import csr_pkg::*;
#(
    parameter int unsigned TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we_i,
    input  logic        ticlr_we_i,
    input  logic [31:0] wmask_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] tcfg_o,
    output logic [31:0] tval_o,
    output logic        ti_o
);

    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               run_q, run_d;
    logic               ti_q, ti_d;
    logic [31:0]        tcfg_wr;
    logic [TIMER_W-1:0] tcfg_new;
    logic               expire;

    assign tcfg_wr  = csr_mwrite(32'(tcfg_q), wmask_i, wvalue_i);
    assign tcfg_new = tcfg_wr[TIMER_W-1:0];
    assign expire   = run_q && (tval_q == '0);

    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        run_d  = run_q;
        ti_d   = ti_q;
        if (ticlr_we_i && wmask_i[TICLR_CLR] && wvalue_i[TICLR_CLR]) begin
            ti_d = 1'b0;
        end
        // Expiry is applied after the clear so a same-cycle set wins.
        if (expire) begin
            ti_d = 1'b1;
        end
        if (tcfg_we_i) begin
            tcfg_d = tcfg_new;
            tval_d = {tcfg_new[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
            run_d  = tcfg_new[TCFG_EN];
        end else if (run_q) begin
            if (!expire) begin
                tval_d = tval_q - TIMER_W'(1);
            end else if (tcfg_q[TCFG_PERIODIC]) begin
                tval_d = {tcfg_q[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
            end else begin
                tval_d = '1;
                run_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_q <= '0;
            tval_q <= '1;
            run_q  <= 1'b0;
            ti_q   <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            run_q  <= run_d;
            ti_q   <= ti_d;
        end
    end

    assign tcfg_o = 32'(tcfg_q);
    assign tval_o = 32'(tval_q);
    assign ti_o   = ti_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: LoongArch-32 CSR file beside WB; combinational reads, clocked writes/exception/ERTN.
// The countdown timer (TCFG, TVAL, TICLR, ESTAT.IS[11]) is built only with `define CSR_TIMER_EN.
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned NUM_SAVE = 4,
    parameter int unsigned TIMER_W  = 32,
    parameter logic [31:0] TID_RST  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_wnum,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ex_ra,
    output logic        has_int
);

    if (NUM_SAVE < 1 || NUM_SAVE > 16 || TIMER_W < 8 || TIMER_W > 32) begin : g_param_check
        $error("csr_unit: NUM_SAVE or TIMER_W out of range");
    end

    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] lie_q, lie_d;
    logic [1:0]  is_sw_q, is_sw_d;
    logic [7:0]  is_hw_q;
    logic        is_ipi_q;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [NUM_SAVE];
    logic [31:0] save_d [NUM_SAVE];
    logic [31:0] tid_q, tid_d;

    logic [31:0] tcfg_v, tval_v;
    logic        is_ti;
    logic [12:0] is_v;
    logic [31:0] wr_old, wr_new;

    assign is_v = {is_ipi_q, is_ti, 1'b0, is_hw_q, is_sw_q};

    function automatic logic [31:0] csr_view(input logic [13:0] num);
        logic [31:0] v;
        v = '0;
        case (num)
            CSR_CRMD:   v = 32'(crmd_q);
            CSR_PRMD:   v = 32'(prmd_q);
            CSR_ECFG:   v = 32'(lie_q);
            CSR_ESTAT:  v = {1'b0, esub_q, ecode_q, 3'b000, is_v};
            CSR_ERA:    v = era_q;
            CSR_BADV:   v = badv_q;
            CSR_EENTRY: v = {eentry_q, 6'b000000};
            CSR_TID:    v = tid_q;
            CSR_TCFG:   v = tcfg_v;
            CSR_TVAL:   v = tval_v;
            default: begin
                for (int unsigned i = 0; i < NUM_SAVE; i++) begin
                    if (num == CSR_SAVE0 + 14'(i)) v = save_q[i];
                end
            end
        endcase
        return v;
    endfunction

    assign csr_rvalue = csr_view(csr_rnum);
    assign wr_old     = csr_view(csr_wnum);
    assign wr_new     = csr_mwrite(wr_old, csr_wmask, csr_wvalue);

`ifdef CSR_TIMER_EN
    csr_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .tcfg_we_i (csr_we && (csr_wnum == CSR_TCFG)),
        .ticlr_we_i(csr_we && (csr_wnum == CSR_TICLR)),
        .wmask_i   (csr_wmask),
        .wvalue_i  (csr_wvalue),
        .tcfg_o    (tcfg_v),
        .tval_o    (tval_v),
        .ti_o      (is_ti)
    );
`else
    assign tcfg_v = '0;
    assign tval_v = '0;
    assign is_ti  = 1'b0;
`endif

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        lie_d    = lie_q;
        is_sw_d  = is_sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        for (int unsigned i = 0; i < NUM_SAVE; i++) begin
            save_d[i] = save_q[i];
        end

        if (csr_we) begin
            case (csr_wnum)
                CSR_CRMD:   crmd_d   = wr_new[CRMD_DATM_HI:CRMD_PLV_LO];
                CSR_PRMD:   prmd_d   = wr_new[PRMD_PIE:PRMD_PPLV_LO];
                CSR_ECFG:   lie_d    = wr_new[ECFG_LIE_HI:ECFG_LIE_LO] & LIE_WMASK;
                CSR_ESTAT:  is_sw_d  = wr_new[ESTAT_IS_SW_HI:ESTAT_IS_LO];
                CSR_ERA:    era_d    = wr_new;
                CSR_BADV:   badv_d   = wr_new;
                CSR_EENTRY: eentry_d = wr_new[31:EENTRY_VA_LO];
                CSR_TID:    tid_d    = wr_new;
                default: begin
                    for (int unsigned i = 0; i < NUM_SAVE; i++) begin
                        if (csr_wnum == CSR_SAVE0 + 14'(i)) save_d[i] = wr_new;
                    end
                end
            endcase
        end

        // Exception commit overrides CSR writes to PRMD/ERA/BADV and CRMD.PLV/IE.
        if (wb_ex) begin
            crmd_d[CRMD_PLV_HI:CRMD_PLV_LO] = 2'b00;
            crmd_d[CRMD_IE]                 = 1'b0;
            prmd_d  = {crmd_q[CRMD_IE], crmd_q[CRMD_PLV_HI:CRMD_PLV_LO]};
            era_d   = wb_pc;
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
            badv_d  = badv_q;
            if (wb_ecode == ECODE_ADEF) begin
                badv_d = wb_pc;
            end else if (wb_ecode == ECODE_ALE) begin
                badv_d = wb_vaddr;
            end
        end else if (ertn_flush) begin
            crmd_d[CRMD_PLV_HI:CRMD_PLV_LO] = prmd_q[PRMD_PPLV_HI:PRMD_PPLV_LO];
            crmd_d[CRMD_IE]                 = prmd_q[PRMD_PIE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q   <= CRMD_RST;
            prmd_q   <= '0;
            lie_q    <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            is_ipi_q <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            tid_q    <= TID_RST;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= hw_int_in;
            is_ipi_q <= ipi_int_in;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            tid_q    <= tid_d;
        end
    end

    always_ff @(posedge clk) begin
        era_q    <= era_d;
        badv_q   <= badv_d;
        eentry_q <= eentry_d;
        for (int unsigned i = 0; i < NUM_SAVE; i++) begin
            save_q[i] <= save_d[i];
        end
    end

    assign ex_entry = {eentry_q, 6'b000000};
    assign ex_ra    = era_q;
    assign has_int  = crmd_q[CRMD_IE] & (|(is_v & lie_q));

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: table-driven CSR read/write vectors plus hand sequences for exception,
// ERTN, interrupt and (with CSR_TIMER_EN) timer behaviour, checked through a scoreboard.
module tb_csr_unit;

    localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04, A_ESTAT = 14'h05;
    localparam logic [13:0] A_ERA = 14'h06, A_BADV = 14'h07, A_EENTRY = 14'h0c, A_TID = 14'h40;
    localparam logic [13:0] A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;
    localparam logic [31:0] TID_INIT = 32'h0000_00a5;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry, ex_ra;
    logic        has_int;

    csr_unit #(
        .NUM_SAVE(2),
        .TIMER_W (32),
        .TID_RST (TID_INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_rnum   (csr_rnum),
        .csr_rvalue (csr_rvalue),
        .csr_we     (csr_we),
        .csr_wnum   (csr_wnum),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .wb_ex      (wb_ex),
        .wb_ecode   (wb_ecode),
        .wb_esubcode(wb_esubcode),
        .wb_pc      (wb_pc),
        .wb_vaddr   (wb_vaddr),
        .ertn_flush (ertn_flush),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .ex_entry   (ex_entry),
        .ex_ra      (ex_ra),
        .has_int    (has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic        we;
        logic [13:0] wnum;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [13:0] rnum;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[$];
    int   checks = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%h", act);
            return;
        end
        e = sb_q.pop_front();
        if (act !== e.exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
    endtask

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] e);
        sb_q.push_back('{n, e});
        sb_check(act);
    endtask

    task automatic rd(input logic [13:0] num, input string n, input logic [31:0] e);
        csr_rnum = num;
        sb_q.push_back('{n, e});
        #1;
        sb_check(csr_rvalue);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_we     = 1'b1;
        csr_wnum   = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        tick();
        csr_we     = 1'b0;
    endtask

    task automatic ex(input logic [5:0] code, input logic [8:0] sub,
                      input logic [31:0] pc, input logic [31:0] va);
        wb_ex       = 1'b1;
        wb_ecode    = code;
        wb_esubcode = sub;
        wb_pc       = pc;
        wb_vaddr    = va;
        tick();
        wb_ex       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  sets;
        logic seen;

        reset = 1'b1;
        csr_rnum = '0; csr_we = 1'b0; csr_wnum = '0; csr_wmask = '0; csr_wvalue = '0;
        wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
        ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        rd(A_CRMD, "rst_crmd", 32'h8);
        rd(A_PRMD, "rst_prmd", 32'h0);
        rd(14'h3f, "rst_unimpl_3f", 32'h0);
        rd(A_ECFG, "rst_ecfg", 32'h0);
        rd(A_TID, "rst_tid", TID_INIT);
        cmp("rst_estat_is", {19'b0, csr_rvalue[12:0] & 13'h0}, 32'h0);
        rd(A_ESTAT, "rst_estat_is_bits", csr_rvalue & 32'h0);
        csr_rnum = A_ESTAT; #1;
        cmp("rst_is_field", {19'b0, csr_rvalue[12:0]}, 32'h0);
        cmp("rst_has_int", {31'b0, has_int}, 32'h0);
`ifdef CSR_TIMER_EN
        rd(A_TVAL, "rst_tval", 32'hffff_ffff);
`else
        rd(A_TVAL, "rst_tval", 32'h0);
`endif

        vt.push_back('{"ecfg_lie_mask",   1'b1, A_ECFG,   32'hffff_ffff, 32'h0000_1fff, A_ECFG,   32'h0000_1bff});
        vt.push_back('{"crmd_full",       1'b1, A_CRMD,   32'hffff_ffff, 32'h0000_0007, A_CRMD,   32'h0000_0007});
        vt.push_back('{"crmd_masked_set", 1'b1, A_CRMD,   32'h0000_0180, 32'h0000_ffff, A_CRMD,   32'h0000_0187});
        vt.push_back('{"crmd_masked_clr", 1'b1, A_CRMD,   32'h0000_0180, 32'h0000_0000, A_CRMD,   32'h0000_0007});
        vt.push_back('{"save1_write",     1'b1, 14'h31,   32'hffff_ffff, 32'hdead_beef, 14'h31,   32'hdead_beef});
        vt.push_back('{"save2_ignored",   1'b1, 14'h32,   32'hffff_ffff, 32'h0000_0001, 14'h32,   32'h0000_0000});
        vt.push_back('{"save1_kept",      1'b0, 14'h00,   32'h0,         32'h0,         14'h31,   32'hdead_beef});
        vt.push_back('{"save0_write",     1'b1, 14'h30,   32'hffff_ffff, 32'h0000_55aa, 14'h30,   32'h0000_55aa});
        vt.push_back('{"tid_full",        1'b1, A_TID,    32'hffff_ffff, 32'h1234_5678, A_TID,    32'h1234_5678});
        vt.push_back('{"tid_masked",      1'b1, A_TID,    32'hffff_0000, 32'habcd_0000, A_TID,    32'habcd_5678});
        vt.push_back('{"eentry_va",       1'b1, A_EENTRY, 32'hffff_ffff, 32'h1c00_8fff, A_EENTRY, 32'h1c00_8fc0});
        vt.push_back('{"prmd_fields",     1'b1, A_PRMD,   32'hffff_ffff, 32'hffff_ffff, A_PRMD,   32'h0000_0007});
        vt.push_back('{"estat_sw_only",   1'b1, A_ESTAT,  32'hffff_ffff, 32'hffff_ffff, A_ESTAT,  32'h0000_0003});
        vt.push_back('{"unimpl_write",    1'b1, 14'h03,   32'hffff_ffff, 32'hffff_ffff, 14'h03,   32'h0000_0000});
        vt.push_back('{"era_write",       1'b1, A_ERA,    32'hffff_ffff, 32'h1234_5670, A_ERA,    32'h1234_5670});
        vt.push_back('{"badv_write",      1'b1, A_BADV,   32'hffff_ffff, 32'h0bad_f00d, A_BADV,   32'h0bad_f00d});
        vt.push_back('{"ticlr_reads_0",   1'b1, A_TICLR,  32'hffff_ffff, 32'h0000_0001, A_TICLR,  32'h0000_0000});
`ifdef CSR_TIMER_EN
        vt.push_back('{"tcfg_stopped",    1'b1, A_TCFG,   32'hffff_ffff, 32'h0000_0012, A_TCFG,   32'h0000_0012});
        vt.push_back('{"tval_loaded",     1'b0, 14'h00,   32'h0,         32'h0,         A_TVAL,   32'h0000_0010});
`else
        vt.push_back('{"tcfg_absent",     1'b1, A_TCFG,   32'hffff_ffff, 32'h0000_0013, A_TCFG,   32'h0000_0000});
        vt.push_back('{"tval_absent",     1'b0, 14'h00,   32'h0,         32'h0,         A_TVAL,   32'h0000_0000});
`endif

        foreach (vt[i]) begin
            csr_we     = vt[i].we;
            csr_wnum   = vt[i].wnum;
            csr_wmask  = vt[i].wmask;
            csr_wvalue = vt[i].wvalue;
            tick();
            csr_we = 1'b0;
            rd(vt[i].rnum, vt[i].name, vt[i].exp);
        end
        cmp("has_int_sw", {31'b0, has_int}, 32'h1);
        cmp("ex_entry_out", ex_entry, 32'h1c00_8fc0);

        // read returns the pre-write value during a write cycle
        csr_we = 1'b1; csr_wnum = A_TID; csr_wmask = '1; csr_wvalue = 32'hcafe_f00d;
        rd(A_TID, "tid_read_during_write", 32'habcd_5678);
        tick();
        csr_we = 1'b0;
        rd(A_TID, "tid_after_write", 32'hcafe_f00d);

        // ADEF exception with a colliding ERA write
        csr_we = 1'b1; csr_wnum = A_ERA; csr_wmask = '1; csr_wvalue = 32'hffff_ffff;
        ex(6'h08, 9'h005, 32'h1c00_0100, 32'hdead_0001);
        csr_we = 1'b0;
        rd(A_CRMD, "ex_crmd", 32'h0);
        rd(A_PRMD, "ex_prmd", 32'h7);
        rd(A_ERA, "ex_era", 32'h1c00_0100);
        rd(A_BADV, "ex_badv_adef", 32'h1c00_0100);
        rd(A_ESTAT, "ex_estat", 32'h0148_0003);
        cmp("ex_ra_out", ex_ra, 32'h1c00_0100);
        cmp("ex_has_int_masked", {31'b0, has_int}, 32'h0);

        ertn_flush = 1'b1; tick(); ertn_flush = 1'b0;
        rd(A_CRMD, "ertn_crmd", 32'h7);
        cmp("ertn_has_int", {31'b0, has_int}, 32'h1);

        ex(6'h09, 9'h000, 32'h1c00_0200, 32'hdead_0001);
        rd(A_BADV, "ex_badv_ale", 32'hdead_0001);
        rd(A_ERA, "ex_era_ale", 32'h1c00_0200);
        ertn_flush = 1'b1; tick(); ertn_flush = 1'b0;

        // SYS leaves BADV alone and drops the same-cycle BADV write
        csr_we = 1'b1; csr_wnum = A_BADV; csr_wmask = '1; csr_wvalue = 32'h0;
        ex(6'h0b, 9'h000, 32'h1c00_0300, 32'h1111_1111);
        csr_we = 1'b0;
        rd(A_BADV, "ex_badv_sys", 32'hdead_0001);

        // wb_ex beats ertn_flush and a CRMD write in the same cycle
        csr_we = 1'b1; csr_wnum = A_CRMD; csr_wmask = 32'h7; csr_wvalue = 32'h3;
        ertn_flush = 1'b1;
        ex(6'h0d, 9'h000, 32'h1c00_0400, 32'h0);
        ertn_flush = 1'b0; csr_we = 1'b0;
        rd(A_CRMD, "prio_ex_crmd", 32'h0);
        rd(A_PRMD, "prio_ex_prmd", 32'h0);

        // ertn_flush beats a CRMD write
        wr(A_PRMD, 32'hffff_ffff, 32'h5);
        csr_we = 1'b1; csr_wnum = A_CRMD; csr_wmask = 32'h7; csr_wvalue = 32'h2;
        ertn_flush = 1'b1; tick();
        ertn_flush = 1'b0; csr_we = 1'b0;
        rd(A_CRMD, "prio_ertn_crmd", 32'h5);
        wr(A_CRMD, 32'hffff_ffff, 32'h7);

        wr(A_ECFG, 32'hffff_ffff, 32'h0);
        cmp("ecfg_clear_has_int", {31'b0, has_int}, 32'h0);
        wr(A_ESTAT, 32'h3, 32'h0);
        wr(A_ECFG, 32'hffff_ffff, 32'h4);
        cmp("hw_idle_has_int", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h01; tick();
        cmp("hw_has_int", {31'b0, has_int}, 32'h1);
        rd(A_ESTAT, "hw_estat", 32'h000d_0004);
        hw_int_in = 8'h00; tick();
        cmp("hw_drop_has_int", {31'b0, has_int}, 32'h0);
        wr(A_ECFG, 32'hffff_ffff, 32'h1000);
        ipi_int_in = 1'b1; tick(); ipi_int_in = 1'b0;
        cmp("ipi_has_int", {31'b0, has_int}, 32'h1);
        rd(A_ESTAT, "ipi_estat", 32'h000d_1000);
        wr(A_ECFG, 32'hffff_ffff, 32'h400);
        rd(A_ECFG, "ecfg_bit10_ro", 32'h0);

`ifdef CSR_TIMER_EN
        wr(A_TCFG, 32'hffff_ffff, 32'h13);
        rd(A_TVAL, "tval_periodic_load", 32'h10);
        csr_rnum = A_ESTAT; #1;
        cyc = 0; seen = csr_rvalue[11];
        while (!seen && cyc < 40) begin
            tick(); cyc++;
            seen = csr_rvalue[11];
        end
        cmp("ti_periodic_cycles", 32'(cyc), 32'd17);
        rd(A_TVAL, "tval_reload", 32'h10);
        wr(A_TICLR, 32'h1, 32'h1);
        csr_rnum = A_ESTAT; #1;
        cmp("ticlr_clears", {31'b0, csr_rvalue[11]}, 32'h0);
        wr(A_TCFG, 32'hffff_ffff, 32'h0);

        wr(A_TCFG, 32'hffff_ffff, 32'h9);
        rd(A_TVAL, "tval_oneshot_load", 32'h8);
        csr_rnum = A_ESTAT; #1;
        cyc = 0; seen = csr_rvalue[11];
        while (!seen && cyc < 40) begin
            tick(); cyc++;
            seen = csr_rvalue[11];
        end
        cmp("ti_oneshot_cycles", 32'(cyc), 32'd9);
        rd(A_TVAL, "tval_oneshot_done", 32'hffff_ffff);
        wr(A_TICLR, 32'h1, 32'h1);
        sets = 0;
        csr_rnum = A_ESTAT;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (csr_rvalue[11]) sets++;
        end
        cmp("ti_oneshot_once", 32'(sets), 32'd0);
        rd(A_TVAL, "tval_oneshot_stays", 32'hffff_ffff);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
